conv_window_mac_seq: RTL
========================

Name: conv_window_mac_seq

Overview:
- Sequential, parametrised successor to the combinational 5x5 window convolver.
- Accepts one KxK signed fixed-point window plus a filter and bias through a valid/ready handshake.
- Time-multiplexes LANES multipliers over the K*K products into a wide accumulator, then rounds, adds bias, saturates and optionally applies ReLU.
- Sits between the window line-buffer and the feature-map writer in the CNN datapath.

Parameters:
- K, 5, kernel side length; window and filter hold K*K elements.
- DATA_W, 16, signed element, bias and output width.
- FRAC_W, 11, fractional bits of every DATA_W operand (Q5.11 by default).
- LANES, 5, products computed per cycle, from 1 to K*K.

Ports:
- clk  in  1  clock; all registers are rising-edge triggered.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  window, filter, bias and relu_en are valid.
- in_ready  out  1  block can accept an operand set.
- window  in  K*K*DATA_W  element i (row-major) at bits [i*DATA_W +: DATA_W].
- filter  in  K*K*DATA_W  same layout as window.
- bias  in  DATA_W  signed, same Q format as the operands.
- relu_en  in  1  clamp negative results to 0.
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_W  signed result.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE; accumulator, index, captured operands and out_data go to 0.
  - out_valid=0 and busy=0; in_ready=0 while rst is high, otherwise 1 in IDLE.
  - Reset mid-operation aborts the job with no output.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture window, filter, bias and relu_en; clear the accumulator; set idx=0; go to MAC.
  - MAC: each cycle, acc += sum of window[j]*filter[j] for j=idx..idx+LANES-1. Indices >= K*K contribute 0. Then idx += LANES. After N=ceil(K*K/LANES) cycles, go to FINAL.
  - FINAL: compute and register out_data; set out_valid=1; go to OUT.
  - OUT: hold out_data and out_valid stable until out_ready=1. On the accepting edge, clear out_valid and go to IDLE.
- Input changes after capture have no effect on the job in flight.
- Latency: out_valid rises N+1 clock edges after the accept edge. For K=5, LANES=5 that is 6 edges.
- Minimum initiation interval: N+3 cycles. in_ready stays 0 from accept until the output handshake completes, with no overlap.
- Arithmetic:
  - Each product is a full 2*DATA_W signed value.
  - Accumulator width is ACC_W = 2*DATA_W + clog2(K*K) + 1 and never overflows.
  - FINAL computes s = acc + (1 << (FRAC_W-1)), then r = (s >>> FRAC_W) + sign-extended bias. This is round-half-up with arithmetic shift.
  - Saturate r to [-(2^(DATA_W-1)), 2^(DATA_W-1)-1].
  - If relu_en=1 and the saturated value is negative, out_data=0.
- out_valid high with out_ready low: out_data must not change.

Test Plan:
- Window all 0x0400 (0.5), filter all 0x0800 (1.0), bias 0, relu_en 0 -> out_data 0x6400 (12.5). out_valid rises exactly 6 edges after accept; busy is high throughout.
- Window and filter all 0x0800 (1.0) -> 25.0 exceeds range -> out_data saturates to 0x7FFF.
- Window all 0xB000 (-10.0), filter all 0x0800 -> out_data 0x8000. Repeat with relu_en=1 -> out_data 0x0000.
- Window element 0 = 0x0001, filter element 0 = 0x0400, all others 0, bias 0x0800 -> out_data 0x0801; the half-LSB rounds up.
- Hold out_ready low for 10 cycles -> out_data and out_valid stay stable and in_ready stays 0. Release out_ready -> next operand set is accepted the cycle after; repeat with LANES=1 (latency 26) and LANES=25 (latency 2).
- Assert rst during MAC cycle 3 -> out_valid stays 0 and the state returns to IDLE. A subsequent job yields the correct value with no residue from the aborted accumulation.

Source files
------------

// File: rtl/conv_window_mac_seq.sv
// Purpose: sequential KxK signed fixed-point window convolver (MAC, round, bias, saturate, optional ReLU).
// Latency: out_valid rises ceil(K*K/LANES)+1 edges after the accept edge; one job in flight at a time.
// Backpressure: in_ready low from accept until the result is taken; out_data/out_valid held while out_ready is low.
module conv_window_mac_seq #(
    parameter int K      = 5,
    parameter int DATA_W = 16,
    parameter int FRAC_W = 11,
    parameter int LANES  = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [K*K*DATA_W-1:0]      window,
    input  logic [K*K*DATA_W-1:0]      filter,
    input  logic [DATA_W-1:0]          bias,
    input  logic                       relu_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       busy
);

    localparam int NE     = K * K;
    localparam int NCYC   = (NE + LANES - 1) / LANES;
    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = 2 * DATA_W + $clog2(NE) + 1;
    localparam int IDX_W  = $clog2(NCYC * LANES + 1);

    // Rounding constant: half an output LSB.
    localparam logic signed [ACC_W-1:0] RND     = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_W - 1);
    // Saturation bounds of a DATA_W signed value, widened to the accumulator width.
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        FINAL = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                     state;
    logic [NE*DATA_W-1:0]       win_q;
    logic [NE*DATA_W-1:0]       flt_q;
    logic [DATA_W-1:0]          bias_q;
    logic                       relu_q;
    logic signed [ACC_W-1:0]    acc;
    logic [IDX_W-1:0]           idx;

    logic [DATA_W-1:0]          lane_a [LANES];
    logic [DATA_W-1:0]          lane_b [LANES];
    logic signed [PROD_W-1:0]   prod   [LANES];
    logic signed [ACC_W-1:0]    lane_sum;

    logic signed [ACC_W-1:0]    rnd_sum;
    logic signed [ACC_W-1:0]    shifted;
    logic signed [ACC_W-1:0]    biased;
    logic signed [ACC_W-1:0]    sat;
    logic [DATA_W-1:0]          result;

    // Handshake outputs follow the registered state; reset forces in_ready low.
    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);

    // Route element idx+l to lane l; elements past the end of the window match no lane and read as 0.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_a[l] = '0;
            lane_b[l] = '0;
            for (int j = 0; j < NE; j++) begin
                if (j >= l && idx == IDX_W'(j - l)) begin
                    lane_a[l] = win_q[j*DATA_W +: DATA_W];
                    lane_b[l] = flt_q[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Full-width signed products of this cycle's lanes, summed at accumulator width.
    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            prod[l]  = $signed({{DATA_W{lane_a[l][DATA_W-1]}}, lane_a[l]})
                     * $signed({{DATA_W{lane_b[l][DATA_W-1]}}, lane_b[l]});
            lane_sum = lane_sum + $signed({{(ACC_W-PROD_W){prod[l][PROD_W-1]}}, prod[l]});
        end
    end

    // Round half-up, drop fraction bits, add bias, saturate, then optional ReLU.
    always_comb begin
        rnd_sum = acc + RND;
        shifted = rnd_sum >>> FRAC_W;
        biased  = shifted + $signed({{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q});
        if (biased > SAT_MAX) begin
            sat = SAT_MAX;
        end else if (biased < SAT_MIN) begin
            sat = SAT_MIN;
        end else begin
            sat = biased;
        end
        if (relu_q && sat[ACC_W-1]) begin
            result = '0;
        end else begin
            result = sat[DATA_W-1:0];
        end
    end

    // Job sequencer: capture, multiply-accumulate over NCYC cycles, finalise, hold until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            win_q     <= '0;
            flt_q     <= '0;
            bias_q    <= '0;
            relu_q    <= 1'b0;
            acc       <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        win_q  <= window;
                        flt_q  <= filter;
                        bias_q <= bias;
                        relu_q <= relu_en;
                        acc    <= '0;
                        idx    <= '0;
                        state  <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + lane_sum;
                    idx <= idx + IDX_W'(LANES);
                    // Last group of lanes covers the final element.
                    if (int'(idx) + LANES >= NE) begin
                        state <= FINAL;
                    end
                end
                FINAL: begin
                    out_data  <= result;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
